sme_kmp_matcher: RTL
====================

SME_KMP_MATCHER -- requirements
Module: sme_kmp_matcher

Interface
REQ-001 SHALL have parameter BYTE, default 8, character width in bits.
REQ-002 SHALL have parameter MAX_PATTERN, default 8, maximum pattern length in characters.
REQ-003 SHALL have parameter MAX_PAT_ADD, default 3, width of pattern index and failure-function entries.
REQ-004 SHALL have parameter STR_ADD_W, default 6, width of string character position.
REQ-005 SHALL have port clk, input, 1, clock; reset is synchronous and active-high.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_valid, input, 1, level: pattern and failure function are stable and valid.
REQ-008 SHALL have port pattern, input, MAX_PATTERN*BYTE, character k in bits [k*BYTE +: BYTE].
REQ-009 SHALL have port last_pat_idx, input, MAX_PAT_ADD, pattern length minus 1.
REQ-010 SHALL have port i_fail_func, input, MAX_PAT_ADD*MAX_PATTERN, entry k is the longest proper border length of pattern[0..k].
REQ-011 SHALL have port s_valid, input, 1, string character valid.
REQ-012 SHALL have port s_char, input, BYTE, string character.
REQ-013 SHALL have port s_last, input, 1, final character of the string.
REQ-014 SHALL have port s_ready, output, 1, character consumed this cycle when s_valid is also high.
REQ-015 SHALL have port o_match_valid, output, 1, one-cycle match pulse.
REQ-016 SHALL have port o_match_pos, output, STR_ADD_W, position of the first character of the match.
REQ-017 SHALL have port o_done, output, 1, scan complete.

Function
REQ-018 SHALL implement states IDLE, LOAD, SCAN and DONE, one-hot encoded.
REQ-019 SHALL transition IDLE->LOAD when i_valid is high, then LOAD->SCAN unconditionally; LOAD latches pattern, last_pat_idx and i_fail_func, and clears match count q and character position p.
REQ-020 SHALL perform one comparison of pattern[q] against s_char per SCAN cycle while s_valid is high.
REQ-021 SHALL, on equal characters, assert s_ready, consume the character, increment p (modulo 2^STR_ADD_W) and set q=q+1.
REQ-022 SHALL, when the incremented q equals last_pat_idx+1, pulse o_match_valid in the next cycle with o_match_pos=(p_of_char-last_pat_idx) mod 2^STR_ADD_W, and set q=ff[last_pat_idx] so overlapping matches are reported.
REQ-023 SHALL, on unequal characters with q=0, assert s_ready, consume the character and leave q=0.
REQ-024 SHALL, on unequal characters with q>0, hold s_ready low, set q=ff[q-1] and re-examine the same character next cycle.
REQ-025 SHALL keep s_ready low outside SCAN.
REQ-026 SHALL move SCAN->DONE in the cycle after consuming a character with s_last high; a match on that character still pulses o_match_valid.
REQ-027 SHALL hold o_done high in DONE and return DONE->IDLE when i_valid is low.
REQ-028 SHALL, if i_valid falls in LOAD or SCAN, abort to IDLE without asserting o_done or further match pulses.
REQ-029 SHALL hold o_match_pos at its last value between pulses.
REQ-030 SHALL support last_pat_idx=0: every equal character is a match and q stays 0.

Reset
REQ-031 SHALL, on reset, enter IDLE with s_ready=0, o_match_valid=0, o_match_pos=0, o_done=0, q=0 and p=0; reset mid-scan discards all progress.

Configuration
REQ-032 SHALL, with SME_MATCH_CNT_EN defined, add output o_match_cnt[7:0] that is cleared in LOAD, increments on each o_match_valid and saturates at 255.
REQ-033 SHALL, without SME_MATCH_CNT_EN, omit the port and its logic.

Structure
REQ-034 SHALL place BYTE, MAX_PATTERN, MAX_PAT_ADD, STR_ADD_W defaults and the state encodings in shared package sme_pkg.
REQ-035 SHALL be a single module with no sub-module.

Verification
REQ-036 SHALL cover: pattern "ABAB", ff{0,0,1,2}, string "ABABAB" -> match pulses with pos 0 then pos 2, then o_done.
REQ-037 SHALL cover: pattern "AAB", ff{0,1,0}, string "AAAB" -> s_ready low exactly one cycle on the third 'A', single match at pos 1.
REQ-038 SHALL cover: pattern "A", string "BAA" -> matches at pos 1 and 2; a match on the s_last character is pulsed before o_done.
REQ-039 SHALL cover: pattern "XY", string "ABCD" -> no o_match_valid, then o_done; o_done clears after i_valid falls.
REQ-040 SHALL cover: reset asserted mid-SCAN -> all outputs zero next cycle and a new run from IDLE is correct.
REQ-041 SHALL cover: with SME_MATCH_CNT_EN, 300 matches of pattern "A" -> o_match_cnt=255.

Source files
------------

// File: rtl/sme_pkg.sv
// Shared defaults and state encodings for the KMP string matcher.
package sme_pkg;

    localparam int SME_BYTE        = 8;
    localparam int SME_MAX_PATTERN = 8;
    localparam int SME_MAX_PAT_ADD = 3;
    localparam int SME_STR_ADD_W   = 6;

    localparam logic [7:0] SME_CNT_MAX = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_LOAD = 4'b0010,
        ST_SCAN = 4'b0100,
        ST_DONE = 4'b1000
    } state_e;

endpackage

// File: rtl/sme_kmp_matcher.sv
// KMP streaming matcher: one pattern/character comparison per SCAN cycle.
// Optional saturating match counter port enabled by SME_MATCH_CNT_EN.
module sme_kmp_matcher
    import sme_pkg::*;
#(
    parameter int BYTE        = SME_BYTE,
    parameter int MAX_PATTERN = SME_MAX_PATTERN,
    parameter int MAX_PAT_ADD = SME_MAX_PAT_ADD,
    parameter int STR_ADD_W   = SME_STR_ADD_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_valid,
    input  logic [MAX_PATTERN*BYTE-1:0]    pattern,
    input  logic [MAX_PAT_ADD-1:0]         last_pat_idx,
    input  logic [MAX_PAT_ADD*MAX_PATTERN-1:0] i_fail_func,
    input  logic                           s_valid,
    input  logic [BYTE-1:0]                s_char,
    input  logic                           s_last,
    output logic                           s_ready,
    output logic                           o_match_valid,
    output logic [STR_ADD_W-1:0]           o_match_pos,
    output logic                           o_done
`ifdef SME_MATCH_CNT_EN
    ,
    output logic [7:0]                     o_match_cnt
`endif
);

    state_e                              state_q, state_d;
    logic [MAX_PATTERN*BYTE-1:0]         pat_q, pat_d;
    logic [MAX_PAT_ADD-1:0]              last_q, last_d;
    logic [MAX_PAT_ADD*MAX_PATTERN-1:0]  ff_q, ff_d;
    logic [MAX_PAT_ADD-1:0]              q_q, q_d;
    logic [STR_ADD_W-1:0]                p_q, p_d;
    logic                                mv_q, mv_d;
    logic [STR_ADD_W-1:0]                pos_q, pos_d;
    logic                                last_seen_q, last_seen_d;

    logic                                chars_eq;
    logic                                consume;
    logic [MAX_PAT_ADD:0]                q_inc;
    logic [MAX_PAT_ADD:0]                len;

    function automatic logic [MAX_PAT_ADD-1:0] ff_at(input logic [MAX_PAT_ADD-1:0] k);
        return ff_q[k*MAX_PAT_ADD +: MAX_PAT_ADD];
    endfunction

    assign chars_eq = (pat_q[q_q*BYTE +: BYTE] == s_char);
    assign q_inc    = {1'b0, q_q} + 1'b1;
    assign len      = {1'b0, last_q} + 1'b1;

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        last_d      = last_q;
        ff_d        = ff_q;
        q_d         = q_q;
        p_d         = p_q;
        mv_d        = 1'b0;
        pos_d       = pos_q;
        last_seen_d = last_seen_q;
        consume     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_valid) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!i_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d     = ST_SCAN;
                    pat_d       = pattern;
                    last_d      = last_pat_idx;
                    ff_d        = i_fail_func;
                    q_d         = '0;
                    p_d         = '0;
                    last_seen_d = 1'b0;
                end
            end
            ST_SCAN: begin
                if (!i_valid) begin
                    state_d = ST_IDLE;
                end else if (last_seen_q) begin
                    // One extra SCAN cycle lets a match on the final character pulse before o_done.
                    state_d = ST_DONE;
                end else if (s_valid) begin
                    if (chars_eq) begin
                        consume = 1'b1;
                        p_d     = p_q + 1'b1;
                        if (q_inc == len) begin
                            mv_d  = 1'b1;
                            pos_d = p_q - STR_ADD_W'(last_q);
                            q_d   = ff_at(last_q);
                        end else begin
                            q_d = q_inc[MAX_PAT_ADD-1:0];
                        end
                    end else if (q_q == '0) begin
                        consume = 1'b1;
                        p_d     = p_q + 1'b1;
                    end else begin
                        q_d = ff_at(q_q - 1'b1);
                    end
                    if (consume && s_last) last_seen_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (!i_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            q_q         <= '0;
            p_q         <= '0;
            mv_q        <= 1'b0;
            pos_q       <= '0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            p_q         <= p_d;
            mv_q        <= mv_d;
            pos_q       <= pos_d;
            last_seen_q <= last_seen_d;
        end
    end

    always_ff @(posedge clk) begin
        pat_q  <= pat_d;
        last_q <= last_d;
        ff_q   <= ff_d;
    end

    assign s_ready       = consume;
    assign o_match_valid = mv_q;
    assign o_match_pos   = pos_q;
    assign o_done        = (state_q == ST_DONE);

`ifdef SME_MATCH_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_LOAD) begin
            cnt_d = '0;
        end else if (mv_q && (cnt_q != SME_CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign o_match_cnt = cnt_q;
`endif

endmodule
